// File: rtl/decodificador_teclado_if.sv
// Keypad matrix pins plus the packed-digit entry bus consumed by setup and the lock FSM.
// The keypad decoder connects through master and its consumers through slave.
interface decodificador_teclado_if #(
  parameter int MAX_DIGITOS = 20
);
  logic [3:0]               col_matriz;
  logic [3:0]               lin_matriz;
  logic [4*MAX_DIGITOS-1:0] digitos_value;
  logic                     digitos_valid;

  modport master (
    input  col_matriz,
    output lin_matriz,
    output digitos_value,
    output digitos_valid
  );

  modport slave (
    output col_matriz,
    input  lin_matriz,
    input  digitos_value,
    input  digitos_valid
  );
endinterface

// File: rtl/decodificador_teclado.sv
// 4x4 keypad scanner with press/release debounce and a nibble-packed entry buffer.
// Entry ends on '#', on '*' over an empty buffer, or after an inactivity timeout.
module decodificador_teclado #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int MAX_DIGITOS     = 20
) (
  input logic                     clk,
  input logic                     rst,
  decodificador_teclado_if.master bus
);

  localparam int BW = 4 * MAX_DIGITOS;
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(MAX_DIGITOS + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_DIGITOS);

  localparam logic [BW-1:0] EMPTY_FILL   = {MAX_DIGITOS{4'hF}};
  localparam logic [BW-1:0] TIMEOUT_FILL = {MAX_DIGITOS{4'hE}};
  localparam logic [BW-1:0] EXIT_FILL    = {{(MAX_DIGITOS-1){4'hF}}, 4'hB};

  // Internal codes for the two non-digit keys; never stored as-is in the buffer.
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [2:0] {
    VARRENDO,
    DEBOUNCE,
    ACEITA,
    PRESSIONADO,
    LIBERANDO
  } estado_t;

  estado_t       estado,     estado_n;
  logic [1:0]    linha,      linha_n;
  logic [SW-1:0] scan_cnt,   scan_cnt_n;
  logic [DW-1:0] deb_cnt,    deb_cnt_n;
  logic [TW-1:0] tmo_cnt,    tmo_cnt_n;
  logic [CW-1:0] count,      count_n;
  logic [BW-1:0] buffer,     buffer_n;
  logic          valid,      valid_n;
  logic          clear_pend, clear_pend_n;
  logic [3:0]    key_col,    key_col_n;
  logic [3:0]    key;

  function automatic logic single_low(input logic [3:0] c);
    return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [3:0] c);
    logic [1:0] ci;
    logic [3:0] k;
    case (c)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      default: ci = 2'd3;
    endcase
    case ({r, ci})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = KEY_STAR;
      4'hD:    k = 4'h0;
      4'hE:    k = KEY_HASH;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign key = key_code(linha, key_col);

  // Next-state logic: scan/debounce FSM, timeout and buffer actions.
  always_comb begin
    estado_n     = estado;
    linha_n      = linha;
    scan_cnt_n   = scan_cnt;
    deb_cnt_n    = deb_cnt;
    tmo_cnt_n    = tmo_cnt;
    count_n      = count;
    buffer_n     = buffer;
    key_col_n    = key_col;
    valid_n      = 1'b0;
    clear_pend_n = 1'b0;

    if (clear_pend) begin
      buffer_n  = EMPTY_FILL;
      count_n   = '0;
      tmo_cnt_n = '0;
    end

    case (estado)
      VARRENDO: begin
        if (single_low(bus.col_matriz)) begin
          key_col_n  = bus.col_matriz;
          deb_cnt_n  = '0;
          scan_cnt_n = '0;
          estado_n   = DEBOUNCE;
        end else if (scan_cnt == SCAN_LAST) begin
          scan_cnt_n = '0;
          linha_n    = linha + 2'd1;
        end else begin
          scan_cnt_n = scan_cnt + 1'b1;
        end

        // Idle timer only matters while something has been typed.
        if (count != '0 && !clear_pend) begin
          if (tmo_cnt == TMO_LAST) begin
            buffer_n     = TIMEOUT_FILL;
            valid_n      = 1'b1;
            clear_pend_n = 1'b1;
            tmo_cnt_n    = '0;
          end else begin
            tmo_cnt_n = tmo_cnt + 1'b1;
          end
        end
      end

      DEBOUNCE: begin
        if (bus.col_matriz != key_col) begin
          deb_cnt_n = '0;
          estado_n  = VARRENDO;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt_n = '0;
          estado_n  = ACEITA;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end

      ACEITA: begin
        estado_n  = PRESSIONADO;
        tmo_cnt_n = '0;
        if (key == KEY_HASH) begin
          valid_n      = 1'b1;
          clear_pend_n = 1'b1;
        end else if (key == KEY_STAR) begin
          if (count == '0) begin
            buffer_n     = EXIT_FILL;
            valid_n      = 1'b1;
            clear_pend_n = 1'b1;
          end else begin
            buffer_n = EMPTY_FILL;
            count_n  = '0;
          end
        end else if (key <= 4'h9) begin
          if (count < MAX_C) begin
            buffer_n = {buffer[BW-5:0], key};
            count_n  = count + 1'b1;
          end
        end
      end

      PRESSIONADO: begin
        if (bus.col_matriz == 4'hF) begin
          deb_cnt_n = '0;
          estado_n  = LIBERANDO;
        end
      end

      LIBERANDO: begin
        if (bus.col_matriz != 4'hF) begin
          deb_cnt_n = '0;
          estado_n  = PRESSIONADO;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt_n = '0;
          estado_n  = VARRENDO;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end

      default: estado_n = VARRENDO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= VARRENDO;
      linha      <= 2'd0;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      tmo_cnt    <= '0;
      count      <= '0;
      buffer     <= EMPTY_FILL;
      valid      <= 1'b0;
      clear_pend <= 1'b0;
      key_col    <= 4'hF;
    end else begin
      estado     <= estado_n;
      linha      <= linha_n;
      scan_cnt   <= scan_cnt_n;
      deb_cnt    <= deb_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      count      <= count_n;
      buffer     <= buffer_n;
      valid      <= valid_n;
      clear_pend <= clear_pend_n;
      key_col    <= key_col_n;
    end
  end

  assign bus.lin_matriz    = ~(4'b0001 << linha);
  assign bus.digitos_value = buffer;
  assign bus.digitos_valid = valid;

endmodule

// File: tb/tb_decodificador_teclado.sv
// Directed bench for decodificador_teclado with a behavioural keypad and shortened timing.
module tb_decodificador_teclado;

  localparam int SCAN     = 4;
  localparam int DEB      = 30;
  localparam int TMO      = 400;
  localparam int MAXD     = 20;

  localparam logic [79:0] ALL_F = {20{4'hF}};
  localparam logic [79:0] ALL_E = {20{4'hE}};

  logic clk = 1'b0;
  logic rst;

  decodificador_teclado_if #(.MAX_DIGITOS(MAXD)) bus ();

  decodificador_teclado #(
    .SCAN_CYCLES     (SCAN),
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .MAX_DIGITOS     (MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad model: the held key pulls its column(s) low only while its row is driven.
  logic       pressed = 1'b0;
  logic [1:0] key_r   = 2'd0;
  logic [3:0] key_m   = 4'b0000;

  assign bus.col_matriz = (pressed && bus.lin_matriz[key_r] == 1'b0) ? ~key_m : 4'hF;

  int n_compared   = 0;
  int n_mismatched = 0;

  int          pulse_count  = 0;
  int          double_count = 0;
  logic [79:0] pulse_value  = '0;
  logic [79:0] after_value  = '0;
  logic        prev_valid   = 1'b0;

  always @(negedge clk) begin
    if (bus.digitos_valid) begin
      pulse_count = pulse_count + 1;
      pulse_value = bus.digitos_value;
    end
    if (prev_valid) after_value = bus.digitos_value;
    if (prev_valid && bus.digitos_valid) double_count = double_count + 1;
    prev_valid = bus.digitos_valid;
  end

  task automatic press(input logic [1:0] r, input logic [3:0] m);
    key_r   = r;
    key_m   = m;
    pressed = 1'b1;
    repeat (80) @(negedge clk);
    pressed = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    if (d == 0) press(2'd3, 4'b0010);
    else        press(2'((d - 1) / 3), 4'(1 << ((d - 1) % 3)));
  endtask

  task automatic press_hash();
    press(2'd3, 4'b0100);
  endtask

  task automatic press_star();
    press(2'd3, 4'b0001);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_compared++;
    if (bus.lin_matriz !== 4'b1110) begin
      n_mismatched++;
      $display("[TB] FAIL reset_lin: got %b expected %b", bus.lin_matriz, 4'b1110);
    end
    n_compared++;
    if (bus.digitos_value !== ALL_F) begin
      n_mismatched++;
      $display("[TB] FAIL reset_value: got %h expected %h", bus.digitos_value, ALL_F);
    end
    n_compared++;
    if (bus.digitos_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.digitos_valid);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_entry();
    int p0;
    p0 = pulse_count;
    press_digit(1);
    press_digit(2);
    press_digit(3);
    press_digit(4);
    n_compared++;
    if (bus.digitos_value !== 80'hFFFF_FFFF_FFFF_FFFF_1234) begin
      n_mismatched++;
      $display("[TB] FAIL clean_buffer: got %h expected %h", bus.digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);
    end
    press_hash();
    n_compared++;
    if (pulse_count - p0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL clean_pulses: got %0d expected 1", pulse_count - p0);
    end
    n_compared++;
    if (pulse_value !== 80'hFFFF_FFFF_FFFF_FFFF_1234) begin
      n_mismatched++;
      $display("[TB] FAIL clean_strobe_value: got %h expected %h", pulse_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);
    end
    n_compared++;
    if (after_value !== ALL_F) begin
      n_mismatched++;
      $display("[TB] FAIL clean_after_strobe: got %h expected %h", after_value, ALL_F);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_count;
    key_r   = 2'd1;
    key_m   = 4'b0010;
    pressed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat (10) @(negedge clk);
      pressed = ~pressed;
    end
    press(2'd1, 4'b0010);
    n_compared++;
    if (bus.digitos_value !== {{19{4'hF}}, 4'h5}) begin
      n_mismatched++;
      $display("[TB] FAIL bounce_single_digit: got %h expected %h", bus.digitos_value, {{19{4'hF}}, 4'h5});
    end
    press(2'd0, 4'b0011);
    n_compared++;
    if (bus.digitos_value !== {{19{4'hF}}, 4'h5}) begin
      n_mismatched++;
      $display("[TB] FAIL two_columns_ignored: got %h expected %h", bus.digitos_value, {{19{4'hF}}, 4'h5});
    end
    press_digit(6);
    press_star();
    n_compared++;
    if (bus.digitos_value !== ALL_F) begin
      n_mismatched++;
      $display("[TB] FAIL star_clears: got %h expected %h", bus.digitos_value, ALL_F);
    end
    n_compared++;
    if (pulse_count - p0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL bounce_no_strobe: got %0d expected 0", pulse_count - p0);
    end
  endtask

  task automatic test_star_empty();
    int p0;
    p0 = pulse_count;
    press_star();
    n_compared++;
    if (pulse_count - p0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL exit_pulses: got %0d expected 1", pulse_count - p0);
    end
    n_compared++;
    if (pulse_value !== {{19{4'hF}}, 4'hB}) begin
      n_mismatched++;
      $display("[TB] FAIL exit_value: got %h expected %h", pulse_value, {{19{4'hF}}, 4'hB});
    end
    n_compared++;
    if (after_value !== ALL_F) begin
      n_mismatched++;
      $display("[TB] FAIL exit_after_strobe: got %h expected %h", after_value, ALL_F);
    end
  endtask

  task automatic test_letters();
    int p0;
    p0 = pulse_count;
    press(2'd0, 4'b1000);
    press(2'd3, 4'b1000);
    n_compared++;
    if (bus.digitos_value !== ALL_F || pulse_count - p0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL letters_ignored: got %h/%0d expected %h/0", bus.digitos_value, pulse_count - p0, ALL_F);
    end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = pulse_count;
    for (int i = 1; i <= 21; i++) press_digit(i % 10);
    n_compared++;
    if (bus.digitos_value !== 80'h1234_5678_9012_3456_7890) begin
      n_mismatched++;
      $display("[TB] FAIL overflow_buffer: got %h expected %h", bus.digitos_value, 80'h1234_5678_9012_3456_7890);
    end
    press_hash();
    n_compared++;
    if (pulse_count - p0 !== 1 || pulse_value !== 80'h1234_5678_9012_3456_7890) begin
      n_mismatched++;
      $display("[TB] FAIL overflow_strobe: got %0d/%h expected 1/%h", pulse_count - p0, pulse_value, 80'h1234_5678_9012_3456_7890);
    end
  endtask

  task automatic test_timeout();
    int p0;
    p0 = pulse_count;
    press_digit(7);
    n_compared++;
    if (pulse_count - p0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_early: got %0d expected 0", pulse_count - p0);
    end
    repeat (500) @(negedge clk);
    n_compared++;
    if (pulse_count - p0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_pulses: got %0d expected 1", pulse_count - p0);
    end
    n_compared++;
    if (pulse_value !== ALL_E) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_value: got %h expected %h", pulse_value, ALL_E);
    end
    n_compared++;
    if (bus.digitos_value !== ALL_F) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_cleared: got %h expected %h", bus.digitos_value, ALL_F);
    end
    p0 = pulse_count;
    repeat (2 * TMO) @(negedge clk);
    n_compared++;
    if (pulse_count - p0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL empty_no_timeout: got %0d expected 0", pulse_count - p0);
    end
  endtask

  task automatic test_reset_debounce();
    int p0;
    press_digit(1);
    press_digit(2);
    press_digit(3);
    n_compared++;
    if (bus.digitos_value !== {{17{4'hF}}, 12'h123}) begin
      n_mismatched++;
      $display("[TB] FAIL prereset_buffer: got %h expected %h", bus.digitos_value, {{17{4'hF}}, 12'h123});
    end
    p0 = pulse_count;
    key_r   = 2'd1;
    key_m   = 4'b0001;
    pressed = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus.lin_matriz !== 4'b1110 || bus.digitos_value !== ALL_F || bus.digitos_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got %b/%h/%b expected 1110/%h/0", bus.lin_matriz, bus.digitos_value, bus.digitos_valid, ALL_F);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pressed = 1'b0;
    repeat (150) @(negedge clk);
    n_compared++;
    if (bus.digitos_value !== ALL_F || pulse_count - p0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL postreset_no_digit: got %h/%0d expected %h/0", bus.digitos_value, pulse_count - p0, ALL_F);
    end
  endtask

  task automatic test_no_back_to_back();
    n_compared++;
    if (double_count !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL valid_back_to_back: got %0d expected 0", double_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_bounce();
    test_star_empty();
    test_letters();
    test_overflow();
    test_timeout();
    test_reset_debounce();
    test_no_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
